// File: rtl/game_state_sequencer.sv
// Hardware side of a game round: command-edge decode, phase FSM driven by the frame tick, round timer.
// Optional feature: define GAME_STATE_SEQ_ADD_TIME_EN to enable the ADD_TIME bonus command.
module game_state_sequencer #(
  parameter int unsigned FRAMES_PER_SEC    = 60,
  parameter int unsigned DEFAULT_ROUND_SEC = 60
) (
  input  logic        Clk,
  input  logic        Reset_h,
  input  logic [31:0] Game_state_in,
  input  logic        Frame_tick,
  output logic [2:0]  Phase,
  output logic [1:0]  Countdown,
  output logic [7:0]  Time_left,
  output logic        Time_up,
  output logic [31:0] Status_word
);

  // state      | meaning
  // PH_TITLE   | idle title screen, waiting for START
  // PH_COUNTDOWN | 3..1 countdown, one digit per second step
  // PH_PLAY    | round running, Time_left counts down
  // PH_PAUSED  | round frozen, frame_cnt and Time_left held
  // PH_OVER    | round finished, waiting for IDLE
  typedef enum logic [2:0] {
    PH_TITLE     = 3'd0,
    PH_COUNTDOWN = 3'd1,
    PH_PLAY      = 3'd2,
    PH_PAUSED    = 3'd3,
    PH_OVER      = 3'd4
  } phase_e;

  localparam logic [2:0] CMD_IDLE     = 3'd0;
  localparam logic [2:0] CMD_START    = 3'd1;
  localparam logic [2:0] CMD_PAUSE    = 3'd2;
  localparam logic [2:0] CMD_RESUME   = 3'd3;
  localparam logic [2:0] CMD_ABORT    = 3'd4;
  localparam logic [2:0] CMD_ADD_TIME = 3'd5;

  localparam logic [7:0] FPS_LAST = 8'(FRAMES_PER_SEC - 1);
  localparam logic [7:0] DEF_SEC  = 8'(DEFAULT_ROUND_SEC);

  phase_e      phase_q, phase_d;
  logic [1:0]  countdown_q, countdown_d;
  logic [7:0]  time_left_q, time_left_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        time_up_q, time_up_d;
  logic [2:0]  cmd_prev_q, cmd_prev_d;

  logic [2:0]  cmd;
  logic [7:0]  round_len;
  logic        cmd_chg;
  logic        tick_ok;
  logic        sec_step;

  assign cmd       = Game_state_in[2:0];
  assign round_len = Game_state_in[15:8];

`ifdef GAME_STATE_SEQ_ADD_TIME_EN
  logic [8:0] add_sum;
  assign add_sum = {1'b0, time_left_q} + {1'b0, Game_state_in[23:16]};
  logic unused_bits;
  assign unused_bits = ^{Game_state_in[31:24], Game_state_in[7:3]};
`else
  logic unused_bits;
  assign unused_bits = ^{Game_state_in[31:16], Game_state_in[7:3], CMD_ADD_TIME};
`endif

  always_comb begin
    phase_d     = phase_q;
    countdown_d = countdown_q;
    time_left_d = time_left_q;
    frame_cnt_d = frame_cnt_q;
    time_up_d   = 1'b0;
    cmd_prev_d  = cmd;

    cmd_chg  = (cmd != cmd_prev_q);
    // a command change swallows a coincident tick
    tick_ok  = Frame_tick && !cmd_chg &&
               ((phase_q == PH_COUNTDOWN) || (phase_q == PH_PLAY));
    sec_step = tick_ok && (frame_cnt_q == FPS_LAST);

    if (cmd_chg) begin
      if ((cmd == CMD_ABORT) && (phase_q != PH_TITLE)) begin
        phase_d     = PH_TITLE;
        countdown_d = 2'd0;
        time_left_d = 8'd0;
        frame_cnt_d = 8'd0;
      end else begin
        unique case (phase_q)
          PH_TITLE: if (cmd == CMD_START) begin
            phase_d     = PH_COUNTDOWN;
            countdown_d = 2'd3;
            frame_cnt_d = 8'd0;
            time_left_d = (round_len == 8'd0) ? DEF_SEC : round_len;
          end
          PH_PLAY: begin
            if (cmd == CMD_PAUSE) phase_d = PH_PAUSED;
`ifdef GAME_STATE_SEQ_ADD_TIME_EN
            if (cmd == CMD_ADD_TIME) time_left_d = add_sum[8] ? 8'hFF : add_sum[7:0];
`endif
          end
          PH_PAUSED: begin
            if (cmd == CMD_RESUME) phase_d = PH_PLAY;
`ifdef GAME_STATE_SEQ_ADD_TIME_EN
            if (cmd == CMD_ADD_TIME) time_left_d = add_sum[8] ? 8'hFF : add_sum[7:0];
`endif
          end
          PH_OVER: if (cmd == CMD_IDLE) phase_d = PH_TITLE;
          default: ;
        endcase
      end
    end else if (tick_ok) begin
      frame_cnt_d = sec_step ? 8'd0 : frame_cnt_q + 8'd1;
      if (sec_step) begin
        if (phase_q == PH_COUNTDOWN) begin
          if (countdown_q > 2'd1) begin
            countdown_d = countdown_q - 2'd1;
          end else begin
            countdown_d = 2'd0;
            phase_d     = PH_PLAY;
          end
        end else if (time_left_q != 8'd0) begin
          time_left_d = time_left_q - 8'd1;
          if (time_left_q == 8'd1) begin
            phase_d   = PH_OVER;
            time_up_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      phase_q     <= PH_TITLE;
      countdown_q <= 2'd0;
      time_left_q <= 8'd0;
      frame_cnt_q <= 8'd0;
      time_up_q   <= 1'b0;
      cmd_prev_q  <= 3'd0;
    end else begin
      phase_q     <= phase_d;
      countdown_q <= countdown_d;
      time_left_q <= time_left_d;
      frame_cnt_q <= frame_cnt_d;
      time_up_q   <= time_up_d;
      cmd_prev_q  <= cmd_prev_d;
    end
  end

  assign Phase       = phase_q;
  assign Countdown   = countdown_q;
  assign Time_left   = time_left_q;
  assign Time_up     = time_up_q;
  assign Status_word = {16'd0, time_left_q, 3'd0, countdown_q, phase_q};

endmodule

// File: tb/tb_game_state_sequencer.sv
// Directed plus randomized check of game_state_sequencer against a per-cycle rule model.
module tb_game_state_sequencer;
  localparam int FPS = 4;
  localparam int DEF = 60;
`ifdef GAME_STATE_SEQ_ADD_TIME_EN
  localparam bit ADD_EN = 1'b1;
`else
  localparam bit ADD_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_h = 1'b1;
  logic [31:0] Game_state_in = 32'd0;
  logic        Frame_tick = 1'b0;
  logic [2:0]  Phase;
  logic [1:0]  Countdown;
  logic [7:0]  Time_left;
  logic        Time_up;
  logic [31:0] Status_word;

  game_state_sequencer #(.FRAMES_PER_SEC(FPS), .DEFAULT_ROUND_SEC(DEF)) dut (
    .Clk(Clk), .Reset_h(Reset_h), .Game_state_in(Game_state_in), .Frame_tick(Frame_tick),
    .Phase(Phase), .Countdown(Countdown), .Time_left(Time_left), .Time_up(Time_up),
    .Status_word(Status_word)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;

  // model state: phase as plain number 0..4
  int m_ph = 0, m_cd = 0, m_tl = 0, m_fc = 0, m_prev = 0, m_up = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [31:0] w, input logic t, input logic r);
    int c;
    bit chg;
    c = int'(w[2:0]);
    chg = (c != m_prev);
    m_prev = c;
    m_up = 0;
    if (r) begin
      m_ph = 0; m_cd = 0; m_tl = 0; m_fc = 0; m_prev = 0;
    end else if (chg) begin
      if (c == 4 && m_ph != 0) begin
        m_ph = 0; m_cd = 0; m_tl = 0; m_fc = 0;
      end else if (m_ph == 0 && c == 1) begin
        m_ph = 1; m_cd = 3; m_fc = 0;
        m_tl = (w[15:8] == 0) ? DEF : int'(w[15:8]);
      end else if (m_ph == 2 && c == 2) m_ph = 3;
      else if (m_ph == 3 && c == 3) m_ph = 2;
      else if (m_ph == 4 && c == 0) m_ph = 0;
      else if (ADD_EN && c == 5 && (m_ph == 2 || m_ph == 3)) begin
        m_tl = m_tl + int'(w[23:16]);
        if (m_tl > 255) m_tl = 255;
      end
    end else if (t && (m_ph == 1 || m_ph == 2)) begin
      m_fc++;
      if (m_fc == FPS) begin
        m_fc = 0;
        if (m_ph == 1) begin
          m_cd--;
          if (m_cd == 0) m_ph = 2;
        end else if (m_tl > 0) begin
          m_tl--;
          if (m_tl == 0) begin m_ph = 4; m_up = 1; end
        end
      end
    end
  endtask

  task automatic cyc(input logic [31:0] w, input logic t, input logic r);
    logic [31:0] sw;
    Game_state_in = w; Frame_tick = t; Reset_h = r;
    @(posedge Clk);
    model(w, t, r);
    #1;
    sw = {16'd0, 8'(m_tl), 3'd0, 2'(m_cd), 3'(m_ph)};
    chk("phase", 32'(Phase), 32'(m_ph));
    chk("countdown", 32'(Countdown), 32'(m_cd));
    chk("time_left", 32'(Time_left), 32'(m_tl));
    chk("time_up", 32'(Time_up), 32'(m_up));
    chk("status", Status_word, sw);
  endtask

  task automatic ticks(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(w, 1'b1, 1'b0);
      cyc(w, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int ups;
    logic [31:0] w;
    // reset, then idle word with ticks
    for (int i = 0; i < 3; i++) cyc(32'd0, 1'b0, 1'b1);
    chk("rst_status", Status_word, 32'd0);
    chk("rst_time_up", 32'(Time_up), 32'd0);
    ticks(32'd0, 10);
    chk("idle_phase", 32'(Phase), 32'd0);
    chk("idle_status", Status_word, 32'd0);

    // start with length 10
    cyc(32'h0000_0A01, 1'b0, 1'b0);
    chk("start_phase", 32'(Phase), 32'd1);
    chk("start_cd", 32'(Countdown), 32'd3);
    chk("start_tl", 32'(Time_left), 32'd10);
    ticks(32'h0000_0A01, 12);
    chk("cd_done_phase", 32'(Phase), 32'd2);
    chk("cd_done_cd", 32'(Countdown), 32'd0);

    // round with 2 seconds runs out
    cyc(32'h0000_0A04, 1'b0, 1'b0);
    cyc(32'h0000_0201, 1'b0, 1'b0);
    ticks(32'h0000_0201, 12);
    chk("short_tl", 32'(Time_left), 32'd2);
    ups = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(32'h0000_0201, 1'b1, 1'b0);
      if (Time_up) ups++;
      if (i == 3) chk("tl_one", 32'(Time_left), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(32'h0000_0201, 1'b1, 1'b0);
      if (Time_up) ups++;
    end
    chk("over_phase", 32'(Phase), 32'd4);
    chk("over_tl", 32'(Time_left), 32'd0);
    chk("time_up_once", 32'(ups), 32'd1);
    cyc(32'h0000_0200, 1'b0, 1'b0);
    chk("idle_to_title", 32'(Phase), 32'd0);

    // pause / resume keeps frame_cnt
    cyc(32'h0000_0A01, 1'b0, 1'b0);
    ticks(32'h0000_0A01, 12);
    ticks(32'h0000_0A01, 2);
    cyc(32'h0000_0A02, 1'b0, 1'b0);
    chk("paused", 32'(Phase), 32'd3);
    ticks(32'h0000_0A02, 20);
    chk("paused_tl", 32'(Time_left), 32'd10);
    cyc(32'h0000_0A03, 1'b0, 1'b0);
    chk("resumed", 32'(Phase), 32'd2);
    cyc(32'h0000_0A03, 1'b1, 1'b0);
    chk("resume_no_step", 32'(Time_left), 32'd10);
    cyc(32'h0000_0A03, 1'b1, 1'b0);
    chk("resume_step", 32'(Time_left), 32'd9);

    // default length, abort in countdown, command beats tick
    cyc(32'h0000_0004, 1'b0, 1'b0);
    cyc(32'h0000_0001, 1'b0, 1'b0);
    chk("default_len", 32'(Time_left), 32'd60);
    cyc(32'h0000_0004, 1'b0, 1'b0);
    chk("abort_status", Status_word, 32'd0);
    cyc(32'h0000_0A01, 1'b0, 1'b0);
    ticks(32'h0000_0A01, 3);
    cyc(32'h0000_0A02, 1'b1, 1'b0);
    chk("tick_discarded", 32'(Countdown), 32'd3);
    cyc(32'h0000_0A02, 1'b1, 1'b0);
    chk("tick_after", 32'(Countdown), 32'd2);

    // ADD_TIME saturation (or no-op without the feature)
    cyc(32'h0000_FA04, 1'b0, 1'b0);
    cyc(32'h0000_FA01, 1'b0, 1'b0);
    ticks(32'h0000_FA01, 12);
    chk("tl_250", 32'(Time_left), 32'd250);
    cyc(32'h0014_0005, 1'b0, 1'b0);
    chk("add_time", 32'(Time_left), ADD_EN ? 32'd255 : 32'd250);

    // randomized run
    w = 32'd0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        w[2:0]   = 3'($urandom_range(0, 7));
        w[15:8]  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
        w[23:16] = 8'($urandom_range(0, 255));
        w[31:24] = 8'($urandom);
      end
      cyc(w, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 499) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
